// File: rtl/sel_seq_pkg.sv
// Shared types and constants for the select sequencer.
// Holds widths, FSM encoding and small datapath helpers.
package sel_seq_pkg;

    localparam int SEL_W        = 3;
    localparam int CNT_W        = 26;
    localparam int MAX_SEL_DEF  = 6;
    localparam int DIV_BASE_DEF = 12_500_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_AUTO   = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic run_cnt;
        logic take_tick;
        logic take_step;
    } ctl_t;

    // Terminal count for a period of base*mult cycles.
    function automatic cnt_t last_count(
        input int unsigned base,
        input int unsigned mult
    );
        return cnt_t'(base * mult - 32'd1);
    endfunction

    // Next select code, wrapping after the top code.
    function automatic sel_t next_sel(
        input sel_t cur,
        input sel_t max_code
    );
        return (cur >= max_code) ? '0 : cur + sel_t'(1);
    endfunction

endpackage

// File: rtl/step_sync_edge.sv
// Two-flop synchronizer plus rising-edge pulse.
// Shared front end for pushbutton style inputs.
module step_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // synchronizer chain and edge-history flop
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/select_sequencer.sv
// Select-code sequencer for a 7:1 mux stage.
// Advances on a prescaled tick (auto) or on a synced Step edge.
module select_sequencer
    import sel_seq_pkg::*;
#(
    parameter int unsigned DIV_BASE = DIV_BASE_DEF,
    parameter int unsigned MAX_SEL  = MAX_SEL_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             step,
    input  logic [1:0]       rate_sel,
    output logic [SEL_W-1:0] mux_select,
    output logic             advance,
    output logic             wrap
);

    localparam sel_t MAX_CODE = sel_t'(MAX_SEL);
    localparam cnt_t LAST0    = last_count(DIV_BASE, 1);
    localparam cnt_t LAST1    = last_count(DIV_BASE, 2);
    localparam cnt_t LAST2    = last_count(DIV_BASE, 3);
    localparam cnt_t LAST3    = last_count(DIV_BASE, 4);

    state_t state_q;
    state_t state_d;
    ctl_t   ctl;
    cnt_t   cnt_q;
    cnt_t   last_sel;
    logic   tick;
    logic   step_rise;
    logic   adv_d;

    step_sync_edge u_step (
        .clock (clock),
        .reset (reset),
        .din   (step),
        .rise  (step_rise)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state follows enable/mode every cycle
    always_comb begin
        state_d = ST_IDLE;
        if (enable) begin
            state_d = mode ? ST_MANUAL : ST_AUTO;
        end
    end

    // per-state control decode
    always_comb begin
        ctl = '0;
        unique case (1'b1)
            (state_q == ST_AUTO): begin
                ctl.run_cnt   = 1'b1;
                ctl.take_tick = 1'b1;
            end
            (state_q == ST_MANUAL): begin
                ctl.take_step = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // terminal count follows rate_sel with no delay
    always_comb begin
        last_sel = LAST0;
        unique case (rate_sel)
            2'd0: last_sel = LAST0;
            2'd1: last_sel = LAST1;
            2'd2: last_sel = LAST2;
            2'd3: last_sel = LAST3;
        endcase
    end

    // >= so a shortened period fires next cycle
    assign tick = ctl.run_cnt && (cnt_q >= last_sel);

    // prescale counter, cleared whenever not in auto
    always_ff @(posedge clock) begin
        if (reset || !ctl.run_cnt) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + cnt_t'(1);
        end
    end

    assign adv_d = (ctl.take_tick && tick)
                || (ctl.take_step && step_rise);

    // select register with coincident pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            mux_select <= '0;
            advance    <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            advance <= adv_d;
            wrap    <= adv_d && (mux_select >= MAX_CODE);
            if (adv_d) begin
                mux_select <= next_sel(mux_select, MAX_CODE);
            end
        end
    end

endmodule

// File: tb/tb_select_sequencer.sv
// Self-checking bench for select_sequencer.
// Two instances (MAX_SEL 6 and 2) against a cycle reference model.
module tb_select_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       md;
    logic       st;
    logic [1:0] rs;

    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       adv_a;
    logic       adv_b;
    logic       wrap_a;
    logic       wrap_b;

    int total = 0;
    int bad   = 0;

    int advs_a;
    int wraps_a;
    int advs_b;

    // reference model: per instance
    int mx[2] = '{6, 2};
    int m_sel[2];
    int m_el[2];
    int m_st[2];
    bit m_adv[2];
    bit m_wrap[2];
    bit h[2][3];

    always #5 clk = ~clk;

    select_sequencer #(
        .DIV_BASE (DIV),
        .MAX_SEL  (6)
    ) dut_a (
        .clock      (clk),
        .reset      (rst),
        .enable     (en),
        .mode       (md),
        .step       (st),
        .rate_sel   (rs),
        .mux_select (sel_a),
        .advance    (adv_a),
        .wrap       (wrap_a)
    );

    select_sequencer #(
        .DIV_BASE (DIV),
        .MAX_SEL  (2)
    ) dut_b (
        .clock      (clk),
        .reset      (rst),
        .enable     (en),
        .mode       (md),
        .step       (st),
        .rate_sel   (rs),
        .mux_select (sel_b),
        .advance    (adv_b),
        .wrap       (wrap_b)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    // Behaviour per edge: mode from last cycle's enable/mode,
    // auto fires after DIV*(rs+1) cycles spent in auto, manual
    // fires two samples after a low->high step sample.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit a;
            a = 1'b0;
            if (rst) begin
                m_sel[i]  = 0;
                m_el[i]   = 0;
                m_st[i]   = 0;
                m_adv[i]  = 1'b0;
                m_wrap[i] = 1'b0;
                h[i][0]   = 1'b0;
                h[i][1]   = 1'b0;
                h[i][2]   = 1'b0;
            end else begin
                if (m_st[i] == 1) begin
                    if (m_el[i] >= DIV * (int'(rs) + 1) - 1) begin
                        m_el[i] = 0;
                        a = 1'b1;
                    end else begin
                        m_el[i]++;
                    end
                end else begin
                    m_el[i] = 0;
                end
                if (m_st[i] == 2 && h[i][1] && !h[i][2]) a = 1'b1;
                m_adv[i]  = a;
                m_wrap[i] = a && (m_sel[i] == mx[i]);
                if (a) m_sel[i] = (m_sel[i] >= mx[i]) ? 0 : m_sel[i] + 1;
                h[i][2] = h[i][1];
                h[i][1] = h[i][0];
                h[i][0] = st;
                m_st[i] = !en ? 0 : (md ? 2 : 1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("sel_a",   32'(sel_a),  32'(m_sel[0]));
        chk("adv_a",   32'(adv_a),  32'(m_adv[0]));
        chk("wrap_a",  32'(wrap_a), 32'(m_wrap[0]));
        chk("sel_b",   32'(sel_b),  32'(m_sel[1]));
        chk("adv_b",   32'(adv_b),  32'(m_adv[1]));
        chk("wrap_b",  32'(wrap_b), 32'(m_wrap[1]));
        chk("range_b", 32'(sel_b <= 3'd2), 32'd1);
        advs_a  += int'(adv_a);
        wraps_a += int'(wrap_a);
        advs_b  += int'(adv_b);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k;
        rst = 1'b1; en = 1'b0; md = 1'b0; st = 1'b0; rs = 2'd0;
        advs_a = 0; wraps_a = 0; advs_b = 0;
        @(negedge clk);

        // reset state
        run(2);
        chk("reset_sel",  32'(sel_a),  32'd0);
        chk("reset_adv",  32'(adv_a),  32'd0);
        chk("reset_wrap", 32'(wrap_a), 32'd0);
        rst = 1'b0;

        // auto, rate 0: 0..6,0 every 4 cycles, one wrap
        en = 1'b1; md = 1'b0; rs = 2'd0;
        advs_a = 0; wraps_a = 0;
        run(29);
        chk("auto_adv_count",  32'(advs_a),  32'd7);
        chk("auto_wrap_count", 32'(wraps_a), 32'd1);
        chk("auto_end_sel",    32'(sel_a),   32'd0);

        // auto, rate 3: 16-cycle spacing, then shorten mid-count
        rs = 2'd3;
        k = 0;
        do begin
            tick();
            k++;
        end while (adv_a !== 1'b1 && k < 40);
        chk("rate3_adv_seen", 32'(adv_a), 32'd1);
        run(15);
        tick();
        chk("rate3_spacing", 32'(adv_a), 32'd1);
        run(10);
        rs = 2'd0;
        tick();
        chk("rate_switch_adv", 32'(adv_a), 32'd1);

        // manual: held step gives one advance, at e2
        md = 1'b1; st = 1'b0;
        run(4);
        advs_a = 0;
        st = 1'b1;
        tick();
        chk("step_e0", 32'(adv_a), 32'd0);
        tick();
        chk("step_e1", 32'(adv_a), 32'd0);
        tick();
        chk("step_e2", 32'(adv_a), 32'd1);
        run(17);
        st = 1'b0;
        run(3);
        st = 1'b1;
        run(2);
        tick();
        chk("step2_e2", 32'(adv_a), 32'd1);
        st = 1'b0;
        run(4);
        chk("manual_adv_count", 32'(advs_a), 32'd2);

        // bring select to 3, then disable with step toggling
        k = 0;
        while (sel_a !== 3'd3 && k < 20) begin
            st = 1'b1;
            run(3);
            st = 1'b0;
            run(2);
            k++;
        end
        chk("reach_3", 32'(sel_a), 32'd3);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            st = 1'($urandom_range(0, 1));
            tick();
            chk("idle_hold",  32'(sel_a), 32'd3);
            chk("idle_noadv", 32'(adv_a), 32'd0);
        end
        st = 1'b0; en = 1'b1; md = 1'b0; rs = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reen_early", 32'(adv_a), 32'd0);
        end
        tick();
        chk("reen_first_adv", 32'(adv_a), 32'd1);
        chk("reen_sel",       32'(sel_a), 32'd4);

        // reset mid-count at select 5
        k = 0;
        while (sel_a !== 3'd5 && k < 40) begin
            tick();
            k++;
        end
        chk("reach_5", 32'(sel_a), 32'd5);
        run(2);
        rst = 1'b1;
        tick();
        chk("midrst_sel",  32'(sel_a),  32'd0);
        chk("midrst_adv",  32'(adv_a),  32'd0);
        chk("midrst_wrap", 32'(wrap_a), 32'd0);
        rst = 1'b0;
        run(8);

        // step already high at reset release, manual
        rst = 1'b1; en = 1'b1; md = 1'b1; st = 1'b1;
        tick();
        rst = 1'b0;
        run(2);
        tick();
        chk("release_step_adv", 32'(adv_a), 32'd1);
        chk("release_step_sel", 32'(sel_a), 32'd1);
        st = 1'b0;
        run(3);

        // MAX_SEL=2 instance over 100+ advances
        md = 1'b0; rs = 2'd0;
        advs_b = 0;
        run(420);
        chk("b_adv_ge_100", 32'(advs_b >= 100), 32'd1);

        // randomized mix of all inputs
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) md = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 23) == 0) rs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)  st = ~st;
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
